pipe_hazard_chain: RTL

PIPE_HAZARD_CHAIN -- requirements
Module: pipe_hazard_chain

---
 rtl/pipe_hazard_chain_if.sv | 45 ++++
 rtl/pipe_hazard_chain.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_chain_if.sv
// Issue / forwarding / writeback bundle for pipe_hazard_chain.
// The master side drives the issue request, load data and pipeline controls;
// the slave side (the chain) returns readiness, forwarded operands,
// writeback contents and event counters.
interface pipe_hazard_chain_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_regw;
    logic              in_load;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              hold;
    logic              flush;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_val;
    logic [DATA_W-1:0] fwd2_val;
    logic              ld_pending;
    logic              wb_valid;
    logic              wb_regw;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_regw, in_load, in_data,
        output mem_rdata, hold, flush,
        input  in_ready, fwd1_hit, fwd2_hit, fwd1_val, fwd2_val, ld_pending,
        input  wb_valid, wb_regw, wb_rd, wb_data, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_regw, in_load, in_data,
        input  mem_rdata, hold, flush,
        output in_ready, fwd1_hit, fwd2_hit, fwd1_val, fwd2_val, ld_pending,
        output wb_valid, wb_regw, wb_rd, wb_data, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_chain.sv
// In-flight instruction chain with operand forwarding, load-use interlock,
// flush of the youngest stages, downstream hold, and saturating stall/flush
// event counters. Stage 1 is the youngest entry, stage STAGES drives writeback.
module pipe_hazard_chain #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int STAGES      = 4,
    parameter int LOAD_STAGE  = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_chain_if.slave bus
);
    logic [STAGES:1]             r_vld;
    logic [STAGES:1]             r_regw;
    logic [STAGES:1]             r_load;
    logic [STAGES:1][ADDR_W-1:0] r_rd;
    logic [STAGES:1][DATA_W-1:0] r_data;
    logic [15:0]                 r_stall_cnt;
    logic [15:0]                 r_flush_cnt;

    logic              w_found1;
    logic              w_found2;
    logic              w_hz1;
    logic              w_hz2;
    logic [DATA_W-1:0] w_sel1;
    logic [DATA_W-1:0] w_sel2;
    logic              w_hazard;
    logic              w_ready;
    logic              w_issue;
    logic              w_hit1;
    logic              w_hit2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scan oldest to youngest so the youngest matching stage is the one left selected.
    always_comb begin
        w_found1 = 1'b0;
        w_found2 = 1'b0;
        w_hz1    = 1'b0;
        w_hz2    = 1'b0;
        w_sel1   = '0;
        w_sel2   = '0;
        for (int s = STAGES; s >= 1; s--) begin
            if (r_vld[s] && r_regw[s] && (r_rd[s] == bus.in_rs1) && (bus.in_rs1 != '0)) begin
                w_found1 = 1'b1;
                w_hz1    = r_load[s] && (s < LOAD_STAGE);
                w_sel1   = r_data[s];
            end
            if (r_vld[s] && r_regw[s] && (r_rd[s] == bus.in_rs2) && (bus.in_rs2 != '0)) begin
                w_found2 = 1'b1;
                w_hz2    = r_load[s] && (s < LOAD_STAGE);
                w_sel2   = r_data[s];
            end
        end
    end

    // A load whose data is not yet valid blocks issue; while in reset only hold matters.
    assign w_hazard = rst && (w_hz1 || w_hz2);
    assign w_ready  = rst ? (!bus.hold && !w_hazard && !bus.flush) : !bus.hold;
    assign w_issue  = bus.in_valid && w_ready;
    assign w_hit1   = rst && w_found1 && !w_hz1;
    assign w_hit2   = rst && w_found2 && !w_hz2;

    // Stage chain: advance unless held; flushed stages become empty bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld  <= '0;
            r_regw <= '0;
            r_load <= '0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (bus.hold) begin
            if (bus.flush) begin
                for (int s = 1; s <= FLUSH_DEPTH; s++) begin
                    r_vld[s]  <= 1'b0;
                    r_regw[s] <= 1'b0;
                    r_load[s] <= 1'b0;
                    r_rd[s]   <= '0;
                    r_data[s] <= '0;
                end
            end
        end else begin
            for (int s = STAGES; s >= 2; s--) begin
                if (bus.flush && ((s - 1) <= FLUSH_DEPTH)) begin
                    r_vld[s]  <= 1'b0;
                    r_regw[s] <= 1'b0;
                    r_load[s] <= 1'b0;
                    r_rd[s]   <= '0;
                    r_data[s] <= '0;
                end else begin
                    r_vld[s]  <= r_vld[s-1];
                    r_regw[s] <= r_regw[s-1];
                    r_load[s] <= r_load[s-1];
                    r_rd[s]   <= r_rd[s-1];
                    if ((s == LOAD_STAGE) && r_vld[s-1] && r_load[s-1]) begin
                        r_data[s] <= bus.mem_rdata;
                    end else begin
                        r_data[s] <= r_data[s-1];
                    end
                end
            end
            r_vld[1]  <= w_issue;
            r_regw[1] <= w_issue && bus.in_regw;
            r_load[1] <= w_issue && bus.in_load;
            r_rd[1]   <= w_issue ? bus.in_rd : '0;
            r_data[1] <= w_issue ? bus.in_data : '0;
        end
    end

    // Saturating event counters, frozen while held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!bus.hold) begin
            if (bus.in_valid && w_hazard && !bus.flush) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (bus.flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.fwd1_hit   = w_hit1;
    assign bus.fwd2_hit   = w_hit2;
    assign bus.fwd1_val   = w_hit1 ? w_sel1 : '0;
    assign bus.fwd2_val   = w_hit2 ? w_sel2 : '0;
    assign bus.ld_pending = rst && r_vld[LOAD_STAGE-1] && r_load[LOAD_STAGE-1];
    assign bus.wb_valid   = r_vld[STAGES];
    assign bus.wb_regw    = r_regw[STAGES];
    assign bus.wb_rd      = r_rd[STAGES];
    assign bus.wb_data    = r_data[STAGES];
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
endmodule
